// File: rtl/wb_sdram_arbiter.sv
// wb_sdram_arbiter
//   Round-robin arbiter that shares the single Wishbone slave port of the
//   SDRAM memory controller among NUM_M masters on the sys_clk domain.
//   - No grant is issued until sdr_init_done is high.
//   - The owner keeps the port for its whole cyc, including cti bursts.
//   - One SWITCH cycle separates consecutive owners.
//   Optional feature, enabled by defining WB_ARB_QUANTUM_EN:
//   - After QUANTUM acks, the owner is forced off at a beat boundary when
//     another master is requesting.
module wb_sdram_arbiter #(
  parameter int NUM_M   = 2,
  parameter int dw      = 32,
  parameter int APP_AW  = 26,
  parameter int QUANTUM = 8
) (
  input  logic                    sys_clk,
  input  logic                    sdram_resetn,
  input  logic                    sdr_init_done,
  input  logic [NUM_M-1:0]        m_cyc_i,
  input  logic [NUM_M-1:0]        m_stb_i,
  input  logic [NUM_M-1:0]        m_we_i,
  input  logic [NUM_M*APP_AW-1:0] m_addr_i,
  input  logic [NUM_M*dw-1:0]     m_dat_i,
  input  logic [NUM_M*dw/8-1:0]   m_sel_i,
  input  logic [NUM_M*3-1:0]      m_cti_i,
  output logic [NUM_M-1:0]        m_ack_o,
  output logic [dw-1:0]           m_dat_o,
  output logic                    s_cyc_o,
  output logic                    s_stb_o,
  output logic                    s_we_o,
  output logic [APP_AW-1:0]       s_addr_o,
  output logic [dw-1:0]           s_dat_o,
  output logic [dw/8-1:0]         s_sel_o,
  output logic [2:0]              s_cti_o,
  input  logic                    s_ack_i,
  input  logic [dw-1:0]           s_dat_i,
  output logic [NUM_M-1:0]        arb_gnt_o
);

  localparam int IW = (NUM_M > 1) ? $clog2(NUM_M) : 1;

  typedef enum logic [1:0] {ST_IDLE, ST_OWN, ST_SWITCH} state_e;

  state_e           state_q, state_d;
  logic [NUM_M-1:0] gnt_q, gnt_d;
  logic [IW-1:0]    last_q, last_d;
  logic [IW-1:0]    own_idx;
  logic [IW-1:0]    pick_idx;
  logic             pick_vld;
  logic             grant_now;
  logic             quantum_hit;   // owner must see wait states this cycle
  logic             quantum_rel;   // owner is released at the next edge

  // Owner index decoded from the registered one-hot grant; 0 when idle so
  // the slave-side mux defaults to master 0.
  always_comb begin
    // NOTE: every combinational output gets a default first so no latch is inferred.
    own_idx = '0;
    for (int i = 0; i < NUM_M; i++) begin
      if (gnt_q[i]) own_idx = IW'(i);
    end
  end

  // Round-robin pick: first requester after last_q, wrapping; the last
  // owner itself is tried last so a sole requester re-wins.
  always_comb begin
    logic [IW:0] cand;
    pick_idx = '0;
    pick_vld = 1'b0;
    cand     = '0;
    for (int i = 1; i <= NUM_M; i++) begin
      cand = {1'b0, last_q} + (IW+1)'(i);
      if (cand >= (IW+1)'(NUM_M)) cand = cand - (IW+1)'(NUM_M);
      if (!pick_vld && m_cyc_i[cand[IW-1:0]]) begin
        pick_vld = 1'b1;
        pick_idx = cand[IW-1:0];
      end
    end
  end

  assign grant_now = (state_q == ST_IDLE) && sdr_init_done && pick_vld;

`ifdef WB_ARB_QUANTUM_EN
  logic [7:0] cnt_q, cnt_d;

  assign quantum_hit = (state_q == ST_OWN) && (cnt_q >= 8'(QUANTUM)) &&
                       (|(m_cyc_i & ~gnt_q)) &&
                       ((s_cti_o == 3'b000) || (s_cti_o == 3'b111));
  // A beat already acked this cycle must complete before handing over.
  assign quantum_rel = quantum_hit && !s_ack_i;

  // Owner ack counter, restarted on each new grant, saturating at 255.
  always_comb begin
    cnt_d = cnt_q;
    if (grant_now) cnt_d = '0;
    else if ((state_q == ST_OWN) && s_ack_i && (cnt_q != 8'hFF)) cnt_d = cnt_q + 8'd1;
  end

  // Ack counter register.
  always_ff @(posedge sys_clk or negedge sdram_resetn) begin
    if (!sdram_resetn) cnt_q <= '0;
    else               cnt_q <= cnt_d;
  end
`else
  // Without the quantum feature QUANTUM has no effect.
  logic unused_quantum;
  assign unused_quantum = ^8'(QUANTUM);
  assign quantum_hit    = 1'b0;
  assign quantum_rel    = 1'b0;
`endif

  // State, grant and rotation pointer registers.
  always_ff @(posedge sys_clk or negedge sdram_resetn) begin
    if (!sdram_resetn) begin
      state_q <= ST_IDLE;
      gnt_q   <= '0;
      last_q  <= IW'(NUM_M - 1);
    end else begin
      // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
      state_q <= state_d;
      gnt_q   <= gnt_d;
      last_q  <= last_d;
    end
  end

  // Next-state logic: grant in IDLE, release on cyc drop or quantum, one SWITCH cycle.
  always_comb begin
    state_d = state_q;
    gnt_d   = gnt_q;
    last_d  = last_q;
    unique case (state_q)
      ST_IDLE: begin
        if (grant_now) begin
          state_d = ST_OWN;
          gnt_d   = NUM_M'(1) << pick_idx;
        end
      end
      ST_OWN: begin
        // sdr_init_done is deliberately ignored here: an active owner is never aborted.
        if (!m_cyc_i[own_idx] || quantum_rel) begin
          state_d = ST_SWITCH;
          gnt_d   = '0;
          last_d  = own_idx;
        end
      end
      ST_SWITCH: state_d = ST_IDLE;
      default:   state_d = ST_IDLE;
    endcase
  end

  // Output logic: slave handshake and ack routing only while a master owns the port.
  always_comb begin
    s_cyc_o = (state_q == ST_OWN);
    s_stb_o = (state_q == ST_OWN) && m_stb_i[own_idx] && !quantum_hit;
    m_ack_o = '0;
    for (int i = 0; i < NUM_M; i++) begin
      m_ack_o[i] = (state_q == ST_OWN) && gnt_q[i] && s_ack_i;
    end
  end

  assign s_we_o    = m_we_i[own_idx];
  assign s_addr_o  = m_addr_i[own_idx*APP_AW +: APP_AW];
  assign s_dat_o   = m_dat_i[own_idx*dw +: dw];
  assign s_sel_o   = m_sel_i[own_idx*(dw/8) +: dw/8];
  assign s_cti_o   = m_cti_i[own_idx*3 +: 3];
  assign m_dat_o   = s_dat_i;
  assign arb_gnt_o = gnt_q;

endmodule

// File: tb/tb_wb_sdram_arbiter.sv
// Self-checking bench for wb_sdram_arbiter (two masters, 32-bit data).
// Directed scenarios followed by randomized traffic from both masters,
// checked against a reference memory and a round-robin grant model.
`timescale 1ns/1ps
module tb_wb_sdram_arbiter;
  localparam int NUM_M = 2;
  localparam int DW    = 32;
  localparam int AW    = 26;
`ifdef WB_ARB_QUANTUM_EN
  localparam int QUANTUM = 4;
`else
  localparam int QUANTUM = 8;
`endif

  logic sys_clk = 1'b0;
  logic sdram_resetn;
  logic sdr_init_done;

  logic          cyc_r [NUM_M];
  logic          stb_r [NUM_M];
  logic          we_r  [NUM_M];
  logic [AW-1:0] adr_r [NUM_M];
  logic [DW-1:0] dat_r [NUM_M];
  logic [3:0]    sel_r [NUM_M];
  logic [2:0]    cti_r [NUM_M];

  logic [NUM_M-1:0]    m_cyc_i, m_stb_i, m_we_i, m_ack_o, arb_gnt_o;
  logic [NUM_M*AW-1:0] m_addr_i;
  logic [NUM_M*DW-1:0] m_dat_i;
  logic [NUM_M*4-1:0]  m_sel_i;
  logic [NUM_M*3-1:0]  m_cti_i;
  logic [DW-1:0]       m_dat_o, s_dat_o, s_dat_i;
  logic                s_cyc_o, s_stb_o, s_we_o, s_ack_i;
  logic [AW-1:0]       s_addr_o;
  logic [3:0]          s_sel_o;
  logic [2:0]          s_cti_o;

  assign m_cyc_i  = {cyc_r[1], cyc_r[0]};
  assign m_stb_i  = {stb_r[1], stb_r[0]};
  assign m_we_i   = {we_r[1],  we_r[0]};
  assign m_addr_i = {adr_r[1], adr_r[0]};
  assign m_dat_i  = {dat_r[1], dat_r[0]};
  assign m_sel_i  = {sel_r[1], sel_r[0]};
  assign m_cti_i  = {cti_r[1], cti_r[0]};

  wb_sdram_arbiter #(.NUM_M(NUM_M), .dw(DW), .APP_AW(AW), .QUANTUM(QUANTUM)) dut (
    .sys_clk(sys_clk), .sdram_resetn(sdram_resetn), .sdr_init_done(sdr_init_done),
    .m_cyc_i(m_cyc_i), .m_stb_i(m_stb_i), .m_we_i(m_we_i), .m_addr_i(m_addr_i),
    .m_dat_i(m_dat_i), .m_sel_i(m_sel_i), .m_cti_i(m_cti_i), .m_ack_o(m_ack_o),
    .m_dat_o(m_dat_o), .s_cyc_o(s_cyc_o), .s_stb_o(s_stb_o), .s_we_o(s_we_o),
    .s_addr_o(s_addr_o), .s_dat_o(s_dat_o), .s_sel_o(s_sel_o), .s_cti_o(s_cti_o),
    .s_ack_i(s_ack_i), .s_dat_i(s_dat_i), .arb_gnt_o(arb_gnt_o)
  );

  always #5 sys_clk = ~sys_clk;

  int checks = 0;
  int errors = 0;

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  function automatic logic [DW-1:0] merge(input logic [DW-1:0] old_v, input logic [DW-1:0] new_v,
                                          input logic [3:0] sel);
    logic [DW-1:0] r;
    r = old_v;
    for (int b = 0; b < 4; b++) if (sel[b]) r[8*b +: 8] = new_v[8*b +: 8];
    return r;
  endfunction

  // ---------------- slave: memory with one-cycle registered ack ----------------
  logic [DW-1:0] smem [1024];
  logic          ack_q;
  logic          ack_force = 1'b0;
  assign s_ack_i = ack_q | ack_force;
  assign s_dat_i = smem[s_addr_o[9:0]];

  always @(posedge sys_clk or negedge sdram_resetn) begin
    if (!sdram_resetn) ack_q <= 1'b0;
    else begin
      if (ack_q && s_cyc_o && s_we_o) smem[s_addr_o[9:0]] <= merge(smem[s_addr_o[9:0]], s_dat_o, s_sel_o);
      ack_q <= s_cyc_o && s_stb_o && !ack_q;
    end
  end

  // ---------------- monitor: round-robin model and ack sanity ----------------
  int               mon_last = NUM_M - 1;
  logic [NUM_M-1:0] mon_prev = '0;
  logic [NUM_M-1:0] mon_exp  = '0;
  bit               mon_pend = 1'b0;
  int               mon_bad  = 0;
  int               m1_acks  = 0;

  always @(negedge sys_clk) begin
    if (!sdram_resetn) begin
      mon_last = NUM_M - 1;
      mon_prev = '0;
      mon_pend = 1'b0;
    end else begin
      if (mon_pend) begin
        check("rotation", arb_gnt_o, mon_exp);
        mon_pend = 1'b0;
      end
      if ($countones(m_ack_o) > 1 || (m_ack_o & ~arb_gnt_o) != '0) mon_bad++;
      if (m_ack_o[1]) m1_acks++;
      // Free cycle (not the one right after an owner) with a request: the
      // next grant goes to the first requester after the previous owner.
      if (arb_gnt_o == '0 && mon_prev == '0 && sdr_init_done && m_cyc_i != '0) begin
        for (int d = NUM_M; d >= 1; d--) begin
          if (m_cyc_i[(mon_last + d) % NUM_M]) mon_exp = NUM_M'(1) << ((mon_last + d) % NUM_M);
        end
        mon_pend = 1'b1;
      end
      if (arb_gnt_o != '0) mon_last = arb_gnt_o[1] ? 1 : 0;
      mon_prev = arb_gnt_o;
    end
  end

  // ---------------- master-side helpers ----------------
  logic [DW-1:0] ref_mem [int];

  task automatic step(input int n);
    repeat (n) begin @(posedge sys_clk); #1; end
  endtask

  task automatic beat(input int k, input logic we, input logic [AW-1:0] a, input logic [DW-1:0] d,
                      input logic [3:0] sel, input logic [2:0] cti,
                      output logic [DW-1:0] rd, output bit ok);
    stb_r[k] = 1'b1; we_r[k] = we; adr_r[k] = a; dat_r[k] = d; sel_r[k] = sel; cti_r[k] = cti;
    ok = 1'b0; rd = '0;
    for (int t = 0; t < 400 && !ok; t++) begin
      @(negedge sys_clk);
      if (m_ack_o[k]) begin ok = 1'b1; rd = m_dat_o; end
      @(posedge sys_clk); #1;
    end
    stb_r[k] = 1'b0;
  endtask

  task automatic xfer(input int k, input logic we, input logic [AW-1:0] a, input logic [DW-1:0] d,
                      input logic [3:0] sel, output logic [DW-1:0] rd, output bit ok);
    cyc_r[k] = 1'b1;
    beat(k, we, a, d, sel, 3'b000, rd, ok);
    cyc_r[k] = 1'b0;
    if (ok && we) ref_mem[int'(a)] = merge(ref_mem.exists(int'(a)) ? ref_mem[int'(a)] : '0, d, sel);
  endtask

  task automatic wait_gnt(output logic [NUM_M-1:0] g, output bit ok);
    ok = 1'b0; g = '0;
    for (int t = 0; t < 100 && !ok; t++) begin
      if (arb_gnt_o != '0) begin ok = 1'b1; g = arb_gnt_o; end
      else step(1);
    end
  endtask

  task automatic rand_master(input int k);
    logic [AW-1:0] written [$];
    logic [AW-1:0] a;
    logic [DW-1:0] d, rd;
    logic [3:0]    sel;
    bit            ok;
    for (int n = 0; n < 25; n++) begin
      step(1 + int'($urandom_range(0, 3)));
      if (written.size() == 0 || $urandom_range(0, 1) == 0) begin
        a   = AW'(32'h300 + k * 16 + int'($urandom_range(0, 15)));
        d   = $urandom;
        sel = ref_mem.exists(int'(a)) ? 4'($urandom_range(1, 15)) : 4'hF;
        xfer(k, 1'b1, a, d, sel, rd, ok);
        check($sformatf("rand_wr_m%0d_done", k), 64'(ok), 64'd1);
        written.push_back(a);
      end else begin
        a = written[$urandom_range(0, written.size() - 1)];
        xfer(k, 1'b0, a, '0, 4'hF, rd, ok);
        check($sformatf("rand_rd_m%0d_done", k), 64'(ok), 64'd1);
        check($sformatf("rand_rd_m%0d_data", k), rd, ref_mem[int'(a)]);
      end
    end
  endtask

  // ---------------- directed sequence ----------------
  initial begin
    logic [DW-1:0]    rd;
    logic [NUM_M-1:0] g;
    bit               ok;
    sdram_resetn  = 1'b0;
    sdr_init_done = 1'b0;
    for (int k = 0; k < NUM_M; k++) begin
      cyc_r[k] = 1'b0; stb_r[k] = 1'b0; we_r[k] = 1'b0; dat_r[k] = '0;
      sel_r[k] = 4'h3 << (2 * k); cti_r[k] = 3'b000;
    end
    adr_r[0] = 26'h111;
    adr_r[1] = 26'h222;
    step(3);

    // Reset state: idle outputs, slave-side mux selecting master 0
    check("rst_gnt", arb_gnt_o, 0);
    check("rst_cyc", s_cyc_o, 0);
    check("rst_stb", s_stb_o, 0);
    check("rst_ack", m_ack_o, 0);
    check("rst_addr_mux", s_addr_o, 26'h111);
    check("rst_sel_mux", s_sel_o, 4'h3);

    // 1) No grant while init not done
    sdram_resetn = 1'b1;
    cyc_r[0] = 1'b1;
    for (int i = 0; i < 20; i++) begin
      step(1);
      check("noinit_gnt", arb_gnt_o, 0);
      check("noinit_cyc", s_cyc_o, 0);
    end
    ack_force = 1'b1;
    #1;
    check("stray_ack_idle", m_ack_o, 0);
    ack_force = 1'b0;
    sdr_init_done = 1'b1;
    step(1);
    check("init_grant", arb_gnt_o, 2'b01);
    check("init_cyc", s_cyc_o, 1);
    sdr_init_done = 1'b0;
    step(1);
    check("init_drop_keeps_owner", arb_gnt_o, 2'b01);
    sdr_init_done = 1'b1;
    cyc_r[0] = 1'b0;
    step(1);
    check("switch_gnt", arb_gnt_o, 0);
    check("switch_cyc", s_cyc_o, 0);
    step(2);

    // 2) Simultaneous requests after reset: master 0 first, then master 1
    sdram_resetn = 1'b0;
    step(2);
    sdram_resetn = 1'b1;
    cyc_r[0] = 1'b1; cyc_r[1] = 1'b1;
    step(1);
    check("both_first", arb_gnt_o, 2'b01);
    cyc_r[0] = 1'b0;
    step(1);
    check("handover_gap1", arb_gnt_o, 0);
    step(1);
    check("handover_gap2", arb_gnt_o, 0);
    step(1);
    check("handover_second", arb_gnt_o, 2'b10);
    cyc_r[1] = 1'b0;
    step(2);

    // 3) m1 writes, m0 reads back
    xfer(1, 1'b1, 26'h0000100, 32'hDEADBEEF, 4'hF, rd, ok);
    check("wr_done", ok, 1);
    xfer(0, 1'b0, 26'h0000100, '0, 4'hF, rd, ok);
    check("rd_done", ok, 1);
    check("rd_after_wr", rd, 32'hDEADBEEF);
    for (int i = 0; i < 4; i++) begin
      xfer(0, 1'b1, AW'(32'h200 + i), 32'hA5000000 + i, 4'hF, rd, ok);
      check("burst_prefill", ok, 1);
    end

    // 4) m0 4-beat incrementing burst with m1 requesting throughout
    step(1);
    cyc_r[0] = 1'b1;
    wait_gnt(g, ok);
    check("burst_grant", g, 2'b01);
    m1_acks = 0;
    cyc_r[1] = 1'b1; stb_r[1] = 1'b1; we_r[1] = 1'b0; adr_r[1] = 26'h100; cti_r[1] = 3'b000;
    for (int b = 0; b < 4; b++) begin
      beat(0, 1'b0, AW'(32'h200 + b), '0, 4'hF, (b == 3) ? 3'b111 : 3'b010, rd, ok);
      check("burst_beat_done", ok, 1);
      check("burst_beat_data", rd, 32'hA5000000 + b);
      check("burst_owner_kept", arb_gnt_o, 2'b01);
    end
    check("burst_no_m1_ack", m1_acks, 0);
    cyc_r[0] = 1'b0;
    beat(1, 1'b0, 26'h100, '0, 4'hF, 3'b000, rd, ok);
    check("after_burst_m1_done", ok, 1);
    check("after_burst_m1_data", rd, 32'hDEADBEEF);
    cyc_r[1] = 1'b0;
    step(2);

    // 5) Reset pulse in the middle of a burst
    cyc_r[0] = 1'b1;
    wait_gnt(g, ok);
    check("midrst_grant", g, 2'b01);
    beat(0, 1'b0, 26'h200, '0, 4'hF, 3'b010, rd, ok);
    check("midrst_beat1", ok, 1);
    stb_r[0] = 1'b1; adr_r[0] = 26'h201; cti_r[0] = 3'b010;
    #1;
    check("midrst_stb_before", s_stb_o, 1);
    #2;
    sdram_resetn = 1'b0;
    #1;
    check("midrst_cyc", s_cyc_o, 0);
    check("midrst_stb", s_stb_o, 0);
    check("midrst_ack", m_ack_o, 0);
    check("midrst_gnt", arb_gnt_o, 0);
    stb_r[0] = 1'b0;
    cyc_r[1] = 1'b1;
    step(2);
    sdram_resetn = 1'b1;
    wait_gnt(g, ok);
    check("postrst_first", g, 2'b01);
    cyc_r[0] = 1'b0; cyc_r[1] = 1'b0;
    step(3);

`ifdef WB_ARB_QUANTUM_EN
    // 6) Quantum handover: m0 classic reads with cyc held, m1 waiting
    sdram_resetn = 1'b0;
    step(2);
    sdram_resetn = 1'b1;
    cyc_r[0] = 1'b1; cyc_r[1] = 1'b1;
    stb_r[1] = 1'b1; we_r[1] = 1'b0; adr_r[1] = 26'h100; cti_r[1] = 3'b000;
    wait_gnt(g, ok);
    check("q_first", g, 2'b01);
    for (int i = 0; i < 4; i++) begin
      beat(0, 1'b0, AW'(32'h200 + i), '0, 4'hF, 3'b000, rd, ok);
      check("q_beat_done", ok, 1);
    end
    stb_r[0] = 1'b1; we_r[0] = 1'b0; adr_r[0] = 26'h100; cti_r[0] = 3'b000;
    ok = 1'b0;
    for (int t = 0; t < 20 && !ok; t++) begin
      if (arb_gnt_o != 2'b01) ok = 1'b1;
      else step(1);
    end
    check("q_release_seen", ok, 1);
    check("q_release_gnt", arb_gnt_o, 0);
    wait_gnt(g, ok);
    check("q_handover", g, 2'b10);
    beat(1, 1'b0, 26'h100, '0, 4'hF, 3'b000, rd, ok);
    check("q_m1_done", ok, 1);
    cyc_r[1] = 1'b0;
    beat(0, 1'b0, 26'h100, '0, 4'hF, 3'b000, rd, ok);
    check("q_m0_resume", ok, 1);
    check("q_m0_data", rd, 32'hDEADBEEF);
    cyc_r[0] = 1'b0;
    step(3);
`endif

    // Randomized traffic from both masters at once
    fork
      rand_master(0);
      rand_master(1);
    join
    step(3);

    check("ack_onehot_owner_only", mon_bad, 0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
